// File: rtl/vote_pkg.sv
// Shared definitions for the vote tally reader: default sizes, FSM state
// encodings and the accumulator width derivation.
// Optional feature macro: VOTE_MARGIN_EN (runner-up count and margin outputs).
`ifndef VOTE_SUM_W
`define VOTE_SUM_W(cnt_w, idx_w) ((cnt_w) + (idx_w))
`endif

package vote_pkg;

  localparam int NUM_CAND_DEF = 4;
  localparam int CNT_W_DEF    = 21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } vote_state_e;

endpackage

// File: rtl/vote_tally_reader_if.sv
// Read port between the tally reader (master) and the counter bank (slave).
// rd_data is valid exactly one cycle after rd_en.
interface vote_tally_reader_if #(
  parameter int CNT_W = 21,
  parameter int IDX_W = 2
);

  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] rd_data;

  modport master (
    output rd_en,
    output rd_idx,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_idx,
    output rd_data
  );

endinterface

// File: rtl/vote_max_cmp.sv
// Registered compare/accumulate stage: running max, its index, running sum
// and tie flag (plus second-highest value when VOTE_MARGIN_EN is defined).
// Exposes the next-state values so the caller can capture the final result
// on the same edge the last datum is absorbed.
module vote_max_cmp #(
  parameter int CNT_W = 21,
  parameter int IDX_W = 2,
  parameter int SUM_W = 23
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [CNT_W-1:0] data_i,
  output logic [CNT_W-1:0] max_d_o,
  output logic [IDX_W-1:0] idx_d_o,
  output logic [SUM_W-1:0] sum_d_o,
`ifdef VOTE_MARGIN_EN
  output logic [CNT_W-1:0] second_d_o,
`endif
  output logic             tie_d_o
);

  logic [CNT_W-1:0] max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             tie_q, tie_d;
`ifdef VOTE_MARGIN_EN
  logic [CNT_W-1:0] second_q, second_d;
`endif

  logic [SUM_W-1:0] data_ext;
  assign data_ext = {{(SUM_W-CNT_W){1'b0}}, data_i};

  // Next running values: clear on scan start, fold in each valid datum;
  // index 0 always seeds the max so stale state never leaks in.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    sum_d = sum_q;
    tie_d = tie_q;
`ifdef VOTE_MARGIN_EN
    second_d = second_q;
`endif
    if (clr_i) begin
      max_d = '0;
      idx_d = '0;
      sum_d = '0;
      tie_d = 1'b0;
`ifdef VOTE_MARGIN_EN
      second_d = '0;
`endif
    end else if (vld_i) begin
      sum_d = sum_q + data_ext;
      if (idx_i == '0) begin
        max_d = data_i;
        idx_d = idx_i;
        tie_d = 1'b0;
`ifdef VOTE_MARGIN_EN
        second_d = '0;
`endif
      end else if (data_i > max_q) begin
        max_d = data_i;
        idx_d = idx_i;
        tie_d = 1'b0;
`ifdef VOTE_MARGIN_EN
        second_d = max_q;
`endif
      end else if (data_i == max_q) begin
        tie_d = 1'b1;
`ifdef VOTE_MARGIN_EN
        second_d = data_i;
`endif
      end else begin
`ifdef VOTE_MARGIN_EN
        if (data_i > second_q) second_d = data_i;
`endif
      end
    end
  end

  // Running-value registers (no reset: every scan starts with a clear).
  always_ff @(posedge clk) begin
    max_q <= max_d;
    idx_q <= idx_d;
    sum_q <= sum_d;
    tie_q <= tie_d;
`ifdef VOTE_MARGIN_EN
    second_q <= second_d;
`endif
  end

  assign max_d_o = max_d;
  assign idx_d_o = idx_d;
  assign sum_d_o = sum_d;
  assign tie_d_o = tie_d;
`ifdef VOTE_MARGIN_EN
  assign second_d_o = second_d;
`endif

endmodule

// File: rtl/vote_tally_reader.sv
// Vote tally reader: scans NUM_CAND counters one per cycle through a
// synchronous read port and reports winner index/count, total and tie.
// Optional feature macro: VOTE_MARGIN_EN adds runner_count and margin.
module vote_tally_reader
  import vote_pkg::*;
#(
  parameter int NUM_CAND = NUM_CAND_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int IDX_W    = $clog2(NUM_CAND),
  parameter int SUM_W    = `VOTE_SUM_W(CNT_W, IDX_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  vote_tally_reader_if.master rd_bus,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    winner_idx,
  output logic [CNT_W-1:0]    winner_count,
  output logic [SUM_W-1:0]    total,
`ifdef VOTE_MARGIN_EN
  output logic [CNT_W-1:0]    runner_count,
  output logic [CNT_W-1:0]    margin,
`endif
  output logic                tie
);

  vote_state_e state_q, state_d;

  logic             rd_en_q, rd_en_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_acc;

  assign start_acc = (state_q == ST_IDLE) && start;

  // State and control-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rd_en_q  <= 1'b0;
      rd_idx_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_en_q  <= rd_en_d;
      rd_idx_q <= rd_idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state: one ISSUE cycle per candidate, one DRAIN, one FIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: if (rd_idx_q == IDX_W'(NUM_CAND - 1)) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs registered from the next state so they align with the state.
  always_comb begin
    rd_en_d  = (state_d == ST_ISSUE);
    rd_idx_d = '0;
    if (state_d == ST_ISSUE && state_q == ST_ISSUE) rd_idx_d = rd_idx_q + IDX_W'(1);
    busy_d   = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d   = (state_d == ST_FIN);
  end

  // ---- p0: read issued last cycle, datum arrives this cycle ----
  logic             vld_p0;
  logic [IDX_W-1:0] idx_p0;

  // Track which reads are in flight; reset drops any pending datum.
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= rd_en_q;
  end

  // Index travels with the read so the compare stage knows its slot.
  always_ff @(posedge clk) begin
    idx_p0 <= rd_idx_q;
  end

  // ---- p1: compare/accumulate ----
  logic [CNT_W-1:0] max_nx;
  logic [IDX_W-1:0] idx_nx;
  logic [SUM_W-1:0] sum_nx;
  logic             tie_nx;
`ifdef VOTE_MARGIN_EN
  logic [CNT_W-1:0] second_nx;
`endif

  vote_max_cmp #(
    .CNT_W (CNT_W),
    .IDX_W (IDX_W),
    .SUM_W (SUM_W)
  ) u_cmp (
    .clk        (clk),
    .clr_i      (start_acc),
    .vld_i      (vld_p0),
    .idx_i      (idx_p0),
    .data_i     (rd_bus.rd_data),
    .max_d_o    (max_nx),
    .idx_d_o    (idx_nx),
    .sum_d_o    (sum_nx),
`ifdef VOTE_MARGIN_EN
    .second_d_o (second_nx),
`endif
    .tie_d_o    (tie_nx)
  );

  // ---- p2: result registers, loaded as the last datum is absorbed ----
  logic [IDX_W-1:0] winner_idx_q;
  logic [CNT_W-1:0] winner_count_q;
  logic [SUM_W-1:0] total_q;
  logic             tie_q;
`ifdef VOTE_MARGIN_EN
  logic [CNT_W-1:0] runner_q;
  logic [CNT_W-1:0] margin_q;
`endif

  // Results update only on the DRAIN->FIN edge so they are valid with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      winner_idx_q   <= '0;
      winner_count_q <= '0;
      total_q        <= '0;
      tie_q          <= 1'b0;
`ifdef VOTE_MARGIN_EN
      runner_q       <= '0;
      margin_q       <= '0;
`endif
    end else if (state_q == ST_DRAIN) begin
      winner_idx_q   <= idx_nx;
      winner_count_q <= max_nx;
      total_q        <= sum_nx;
      tie_q          <= tie_nx;
`ifdef VOTE_MARGIN_EN
      runner_q       <= second_nx;
      margin_q       <= tie_nx ? '0 : (max_nx - second_nx);
`endif
    end
  end

  assign rd_bus.rd_en  = rd_en_q;
  assign rd_bus.rd_idx = rd_idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign winner_idx    = winner_idx_q;
  assign winner_count  = winner_count_q;
  assign total         = total_q;
  assign tie           = tie_q;
`ifdef VOTE_MARGIN_EN
  assign runner_count  = runner_q;
  assign margin        = margin_q;
`endif

endmodule

// File: doc/vote_tally_reader.md
Name: vote_tally_reader

Overview:
- Reads back the per-candidate vote counters (21-bit `count` registers) through a synchronous read port, one candidate per cycle.
- Reports winner index, winner count, total votes and a tie flag.
- Sits between the counter bank and the result display/announce logic; started by a one-cycle `start` request.

Parameters:
- NUM_CAND, 4, number of candidates/counters scanned (2..16).
- CNT_W, 21, width of each counter value.
- IDX_W, $clog2(NUM_CAND), width of candidate index.
- SUM_W, CNT_W+IDX_W, width of total-vote accumulator.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  scan request, sampled only in IDLE
- rd_en  output  1  read strobe to counter bank
- rd_idx  output  IDX_W  candidate index being read
- rd_data  input  CNT_W  counter value; valid exactly one cycle after rd_en
- busy  output  1  high from the cycle after start acceptance until the cycle before done
- done  output  1  one-cycle pulse; results valid from this cycle
- winner_idx  output  IDX_W  index of the highest count
- winner_count  output  CNT_W  highest count
- total  output  SUM_W  sum of all counts
- tie  output  1  max value held by more than one candidate

Behaviour:
- Reset values: rd_en=0, rd_idx=0, busy=0, done=0, winner_idx=0, winner_count=0, total=0, tie=0; state=IDLE.
- FSM: IDLE -> ISSUE -> DRAIN -> FIN -> IDLE.
- IDLE: start=1 at edge T is accepted. The running max, running index, running sum and tie are cleared. Previous results hold until FIN.
- ISSUE (cycles T+1..T+NUM_CAND):
  - rd_en=1, rd_idx=0,1,...,NUM_CAND-1 on consecutive cycles.
  - The state moves to DRAIN after issuing index NUM_CAND-1.
- Compare pipeline: each cycle rd_data is valid (T+2..T+NUM_CAND+1):
  - sum += rd_data, zero-extended to SUM_W.
  - If rd_data > max: max=rd_data, idx=current, tie=0.
  - Else if rd_data == max: tie=1.
  - Index 0 always loads max unconditionally.
- DRAIN: one cycle, rd_en=0; the last datum is compared.
- FIN (T+NUM_CAND+2): outputs are registered from the running values, done=1 for exactly this cycle, busy=0. Next state is IDLE.
- busy=1 in ISSUE and DRAIN only.
- Tie rule: the lowest index with the max wins; tie=1 whenever ≥2 candidates share the max. All-zero counts give winner 0, tie=1.
- No overflow is possible: SUM_W holds NUM_CAND*(2^CNT_W-1).
- start while busy/FIN is ignored, with no queuing.
- start held high continuously re-triggers one cycle after each FIN.
- rst mid-scan: all outputs return to reset values next edge, including the result registers. Any in-flight rd_data is discarded.
- rd_data is ignored in every cycle not following an rd_en.

Optional Feature:
- Macro `VOTE_MARGIN_EN`.
- Defined:
  - Adds outputs `runner_count[CNT_W-1:0]` (second-highest value, equal to the max if tied) and `margin[CNT_W-1:0]` (winner_count - runner_count, 0 on tie).
  - Tracks the second max in the compare stage.
  - Both outputs reset to 0 and update in FIN.
- Undefined: the ports and the logic are absent; all other timing is identical.

Decomposition:
- Shared package/include `vote_pkg`:
  - Defaults for CNT_W=21 and NUM_CAND=4.
  - State encodings IDLE/ISSUE/DRAIN/FIN (2-bit).
  - SUM_W derivation macro.
- One sub-module, `vote_max_cmp`: a registered compare/accumulate stage. It holds max, idx, sum, tie (and second max under `VOTE_MARGIN_EN`) and has clear/valid inputs.
- The FSM and read-address generator stay in the top module.

Test Plan:
- All scenarios use NUM_CAND=4, CNT_W=21, and a bench model of the counter bank with 1-cycle read latency.
- Counts {5,12,7,3}, start pulse at T -> rd_idx 0..3 at T+1..T+4; done at T+6 with winner_idx=1, winner_count=12, total=27, tie=0.
- Counts {9,2,9,0} -> winner_idx=0, winner_count=9, total=20, tie=1. Under `VOTE_MARGIN_EN`: runner_count=9, margin=0.
- Counts {0,0,0,0} -> winner_idx=0, winner_count=0, total=0, tie=1. Counts {1,4,2,3} with the macro -> runner_count=3, margin=1.
- All counts 2097151 -> total=8388604 (no wrap), winner_idx=0, tie=1.
- Counts {5,12,7,3}; start re-pulsed at T+2 -> ignored: exactly one done, at T+6, with the first-scan results.
- Scenario 1 with rst=1 at T+3 -> next edge: all outputs 0, no done pulse. Restart after reset yields the scenario-1 results on schedule.
